// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline hazard sources in, stage enables/clears and perf counters out.
// master = pipeline side, slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
   parameter int unsigned CW = 16
);
   logic [4:0]    id_rs1;
   logic [4:0]    id_rs2;
   logic          idex_mem_read;
   logic [4:0]    idex_rd;
   logic          exmem_mem_read;
   logic          exmem_mem_write;
   logic          exmem_branch;
   logic          exmem_zero;
   logic          dmem_ack;

   logic          dmem_req;
   logic          pc_write;
   logic          pc_src;
   logic          ifid_write;
   logic          idex_write;
   logic          exmem_write;
   logic          memwb_write;
   logic          ifid_flush;
   logic          idex_flush;
   logic          exmem_flush;
   logic          memwb_flush;
   logic          bus_error;
   logic [CW-1:0] stall_count;
   logic [CW-1:0] flush_count;

   modport master (
      output id_rs1, id_rs2, idex_mem_read, idex_rd, exmem_mem_read, exmem_mem_write,
             exmem_branch, exmem_zero, dmem_ack,
      input  dmem_req, pc_write, pc_src, ifid_write, idex_write, exmem_write, memwb_write,
             ifid_flush, idex_flush, exmem_flush, memwb_flush, bus_error, stall_count, flush_count
   );

   modport slave (
      input  id_rs1, id_rs2, idex_mem_read, idex_rd, exmem_mem_read, exmem_mem_write,
             exmem_branch, exmem_zero, dmem_ack,
      output dmem_req, pc_write, pc_src, ifid_write, idex_write, exmem_write, memwb_write,
             ifid_flush, idex_flush, exmem_flush, memwb_flush, bus_error, stall_count, flush_count
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, MEM-stage branches, slow dmem.
// Control outputs are combinational so hazards act on the same edge that exposes them.
module pipeline_hazard_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CW      = 16
) (
   input logic                   clk,
   input logic                   reset,
   pipeline_hazard_ctrl_if.slave hz
);
   localparam int unsigned WW = 8;

   typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_e;

   state_e        state_q, state_d;
   logic [WW-1:0] wait_q, wait_d;
   logic          bus_error_q, bus_error_d;
   logic [CW-1:0] stall_q, stall_d;
   logic [CW-1:0] flush_q, flush_d;

   logic mem_op, taken, load_use, freeze, br_flush, stall_inc;

   assign mem_op   = hz.exmem_mem_read | hz.exmem_mem_write;
   assign taken    = hz.exmem_branch & hz.exmem_zero;
   assign load_use = hz.idex_mem_read & (hz.idex_rd != 5'd0) &
                     ((hz.idex_rd == hz.id_rs1) | (hz.idex_rd == hz.id_rs2));

   // Next state and stage control, priority ERROR > freeze > branch flush > load-use.
   always_comb begin
      state_d        = state_q;
      wait_d         = wait_q;
      bus_error_d    = bus_error_q;
      freeze         = 1'b0;
      br_flush       = 1'b0;
      hz.dmem_req    = 1'b0;
      hz.pc_write    = 1'b1;
      hz.pc_src      = 1'b0;
      hz.ifid_write  = 1'b1;
      hz.idex_write  = 1'b1;
      hz.exmem_write = 1'b1;
      hz.memwb_write = 1'b1;
      hz.ifid_flush  = 1'b0;
      hz.idex_flush  = 1'b0;
      hz.exmem_flush = 1'b0;
      hz.memwb_flush = 1'b0;

      if (reset) begin
         hz.pc_write    = 1'b0;
         hz.ifid_write  = 1'b0;
         hz.idex_write  = 1'b0;
         hz.exmem_write = 1'b0;
         hz.memwb_write = 1'b0;
         hz.ifid_flush  = 1'b1;
         hz.idex_flush  = 1'b1;
         hz.exmem_flush = 1'b1;
         hz.memwb_flush = 1'b1;
         state_d        = RUN;
         wait_d         = '0;
         bus_error_d    = 1'b0;
      end else if (state_q == ERROR) begin
         hz.pc_write    = 1'b0;
         hz.ifid_write  = 1'b0;
         hz.idex_write  = 1'b0;
         hz.exmem_write = 1'b0;
         hz.memwb_write = 1'b0;
         hz.memwb_flush = 1'b1;
      end else begin
         hz.dmem_req = mem_op;
         freeze      = (state_q == RUN) ? (mem_op & ~hz.dmem_ack) : ~hz.dmem_ack;
         if (freeze) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_write  = 1'b0;
            hz.exmem_write = 1'b0;
            hz.memwb_flush = 1'b1;
            if (state_q == RUN) begin
               state_d = MEM_WAIT;
               wait_d  = '0;
            end else if (wait_q == WW'(TIMEOUT - 1)) begin
               state_d     = ERROR;
               bus_error_d = 1'b1;
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end else begin
            state_d = RUN;
            wait_d  = '0;
            // A taken branch squashes the younger stages, so a coincident load-use is moot.
            if (taken) begin
               br_flush       = 1'b1;
               hz.pc_src      = 1'b1;
               hz.ifid_flush  = 1'b1;
               hz.idex_flush  = 1'b1;
               hz.exmem_flush = 1'b1;
            end else if (load_use) begin
               hz.pc_write   = 1'b0;
               hz.ifid_write = 1'b0;
               hz.idex_flush = 1'b1;
            end
         end
      end

      stall_inc = ~reset & (state_q != ERROR) & ~hz.pc_write;
      stall_d   = (stall_inc && (stall_q != '1)) ? stall_q + CW'(1) : stall_q;
      flush_d   = (br_flush && (flush_q != '1)) ? flush_q + CW'(1) : flush_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         wait_q      <= '0;
         bus_error_q <= 1'b0;
         stall_q     <= '0;
         flush_q     <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         bus_error_q <= bus_error_d;
         stall_q     <= stall_d;
         flush_q     <= flush_d;
      end
   end

   assign hz.bus_error   = bus_error_q;
   assign hz.stall_count = stall_q;
   assign hz.flush_count = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with TIMEOUT=4, CW=3.
module tb_pipeline_hazard_ctrl;
   localparam int unsigned CW = 3;

   // {pc_write, pc_src, ifid/idex/exmem/memwb_write, ifid/idex/exmem/memwb_flush, dmem_req}
   localparam logic [10:0] V_RESET    = 11'b0_0_0000_1111_0;
   localparam logic [10:0] V_NORMAL   = 11'b1_0_1111_0000_0;
   localparam logic [10:0] V_NORM_REQ = 11'b1_0_1111_0000_1;
   localparam logic [10:0] V_LOADUSE  = 11'b0_0_0111_0100_0;
   localparam logic [10:0] V_BRANCH   = 11'b1_1_1111_1110_0;
   localparam logic [10:0] V_BR_REQ   = 11'b1_1_1111_1110_1;
   localparam logic [10:0] V_FREEZE   = 11'b0_0_0001_0001_1;
   localparam logic [10:0] V_ERROR    = 11'b0_0_0000_0001_0;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   pipeline_hazard_ctrl_if #(.CW(CW)) hz ();

   pipeline_hazard_ctrl #(.TIMEOUT(4), .CW(CW)) u_dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   always #5 clk = ~clk;

   function automatic logic [10:0] ctrl_vec();
      return {hz.pc_write, hz.pc_src, hz.ifid_write, hz.idex_write, hz.exmem_write,
              hz.memwb_write, hz.ifid_flush, hz.idex_flush, hz.exmem_flush,
              hz.memwb_flush, hz.dmem_req};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      hz.id_rs1          = 5'd0;
      hz.id_rs2          = 5'd0;
      hz.idex_mem_read   = 1'b0;
      hz.idex_rd         = 5'd0;
      hz.exmem_mem_read  = 1'b0;
      hz.exmem_mem_write = 1'b0;
      hz.exmem_branch    = 1'b0;
      hz.exmem_zero      = 1'b0;
      hz.dmem_ack        = 1'b0;
   endtask

   // Inputs are already applied; check control this cycle, then advance one edge.
   task automatic step(input string tag, input logic [10:0] exp);
      #1;
      chk(tag, 32'(ctrl_vec()), 32'(exp));
      @(posedge clk);
      #1;
   endtask

   task automatic counters(input string tag, input int st, input int fl, input logic be);
      chk({tag, "_stall"}, 32'(hz.stall_count), 32'(st));
      chk({tag, "_flush"}, 32'(hz.flush_count), 32'(fl));
      chk({tag, "_buserr"}, 32'(hz.bus_error), 32'(be));
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      step(tag, V_RESET);
      reset = 1'b0;
      idle();
   endtask

   initial begin
      reset = 1'b1;
      idle();
      @(posedge clk);
      #1;
      do_reset("reset_ctrl");
      counters("reset", 0, 0, 1'b0);
      step("idle_normal", V_NORMAL);

      // Load-use on rs2, then the same with rd = x0.
      hz.idex_mem_read = 1'b1; hz.idex_rd = 5'd5; hz.id_rs2 = 5'd5;
      step("loaduse", V_LOADUSE);
      counters("loaduse", 1, 0, 1'b0);
      idle();
      step("loaduse_after", V_NORMAL);
      hz.idex_mem_read = 1'b1; hz.idex_rd = 5'd0; hz.id_rs2 = 5'd0;
      step("loaduse_x0", V_NORMAL);
      hz.idex_rd = 5'd7; hz.id_rs1 = 5'd7;
      step("loaduse_rs1", V_LOADUSE);
      counters("loaduse_rs1", 2, 0, 1'b0);

      // Taken branch, then not-taken.
      idle();
      hz.exmem_branch = 1'b1; hz.exmem_zero = 1'b1;
      step("branch_taken", V_BRANCH);
      counters("branch", 2, 1, 1'b0);
      hz.exmem_zero = 1'b0;
      step("branch_not_taken", V_NORMAL);

      // Load-use coincident with taken: flush only.
      hz.exmem_zero = 1'b1; hz.idex_mem_read = 1'b1; hz.idex_rd = 5'd9; hz.id_rs1 = 5'd9;
      step("lu_and_branch", V_BRANCH);
      counters("lu_and_branch", 2, 2, 1'b0);

      // Slow load, ack on the 4th cycle.
      idle();
      hz.exmem_mem_read = 1'b1;
      step("slow_freeze1", V_FREEZE);
      step("slow_freeze2", V_FREEZE);
      step("slow_freeze3", V_FREEZE);
      hz.dmem_ack = 1'b1;
      step("slow_release", V_NORM_REQ);
      counters("slow_load", 5, 2, 1'b0);
      step("slow_ack_run", V_NORM_REQ);
      idle();

      // mem_op with pending ack plus taken: freeze, then flush on release.
      hz.exmem_mem_write = 1'b1; hz.exmem_branch = 1'b1; hz.exmem_zero = 1'b1;
      step("memop_branch_freeze", V_FREEZE);
      hz.dmem_ack = 1'b1;
      step("memop_branch_release", V_BR_REQ);
      counters("memop_branch", 6, 3, 1'b0);

      // Saturation of stall_count at 7.
      idle();
      hz.idex_mem_read = 1'b1; hz.idex_rd = 5'd3; hz.id_rs2 = 5'd3;
      for (int i = 0; i < 10; i++) step("sat_loaduse", V_LOADUSE);
      counters("saturate", 7, 3, 1'b0);

      // Timeout into ERROR with TIMEOUT = 4.
      do_reset("reset_before_timeout");
      counters("reset2", 0, 0, 1'b0);
      hz.exmem_mem_write = 1'b1;
      step("to_run_freeze", V_FREEZE);
      for (int i = 0; i < 4; i++) step("to_wait_freeze", V_FREEZE);
      counters("timeout", 5, 0, 1'b1);
      step("error_ctrl", V_ERROR);
      hz.dmem_ack = 1'b1;
      step("error_ignores_ack", V_ERROR);
      counters("error_sticky", 5, 0, 1'b1);
      do_reset("reset_in_error");
      counters("after_error_reset", 0, 0, 1'b0);
      step("after_error_run", V_NORMAL);

      // Reset asserted mid-MEM_WAIT.
      hz.exmem_mem_read = 1'b1;
      step("midwait_freeze1", V_FREEZE);
      step("midwait_freeze2", V_FREEZE);
      do_reset("reset_midwait");
      counters("after_midwait_reset", 0, 0, 1'b0);
      step("after_midwait_run", V_NORMAL);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage RV64 pipeline. Each cycle it decides whether the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers advance, hold or are cleared. It covers load-use hazards, taken branches resolved in MEM, and multi-cycle data-memory accesses. It also keeps saturating performance counters and latches a sticky error on a data-memory timeout.

## Interface
- TIMEOUT, 16: maximum wait cycles for dmem_ack before entering ERROR (1..255).
- CW, 16: width of the performance counters.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- idex_mem_read  in  1  ID/EX MemRead.
- idex_rd  in  5  ID/EX destination register.
- exmem_mem_read, exmem_mem_write  in  1 each  EX/MEM MemRead / MemWrite.
- exmem_branch, exmem_zero  in  1 each  EX/MEM branch and zero flags.
- dmem_ack  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data-memory access request.
- pc_write  out  1  PC load enable.
- pc_src  out  1  1 selects the EX/MEM branch target.
- ifid_write, idex_write, exmem_write, memwb_write  out  1 each  register load enables (0 = hold).
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  synchronous clear to a bubble.
- bus_error  out  1  sticky timeout error.
- stall_count, flush_count  out  CW each  saturating performance counters.

## Operation
- States: RUN, MEM_WAIT, ERROR. Reset sets state to RUN, wait counter to 0, bus_error to 0 and both counters to 0.
- Control outputs are combinational from state and inputs.
- While reset is high: all *_write = 0, all *_flush = 1, pc_write = 0, pc_src = 0, dmem_req = 0.
- Default in RUN is normal flow: all write = 1, all flush = 0, pc_write = 1.
- Definitions:
  - mem_op = exmem_mem_read | exmem_mem_write.
  - taken = exmem_branch & exmem_zero.
  - load_use = idex_mem_read & idex_rd != 0 & (idex_rd == id_rs1 | idex_rd == id_rs2).
- dmem_req = mem_op in RUN and MEM_WAIT; 0 in ERROR.
- Priority per cycle, highest first: ERROR > memory freeze > branch flush > load-use stall.
- Memory freeze applies in RUN when mem_op & !dmem_ack, and in MEM_WAIT when !dmem_ack.
  - Outputs: pc_write = 0; ifid/idex/exmem write = 0; memwb_flush = 1.
  - RUN goes to MEM_WAIT. MEM_WAIT increments the wait counter.
- MEM_WAIT with dmem_ack: normal flow this cycle, then RUN; wait counter clears.
- MEM_WAIT when the wait counter reaches TIMEOUT with no ack: go to ERROR and set bus_error.
- ERROR: pc_write = 0, all write = 0, memwb_flush = 1, dmem_req = 0. Only reset leaves ERROR.
- Branch flush (taken, no freeze): pc_src = 1, pc_write = 1, ifid_flush = idex_flush = exmem_flush = 1. The MEM-stage branch still writes MEM/WB normally.
- Load-use stall (no freeze, not taken): pc_write = 0, ifid_write = 0, idex_flush = 1. EX/MEM and MEM/WB advance.
  - load_use coincident with taken: the flush wins, and the stall is dropped.
- If taken and mem_op are both set, the freeze is handled first. Because EX/MEM is held, taken is re-evaluated on the release cycle.
- stall_count increments once per cycle with pc_write = 0 in RUN or MEM_WAIT. It does not count in ERROR or during reset.
- flush_count increments once per branch flush.
- Both counters saturate at 2^CW-1.

## Timing
- Stall and flush decisions take effect on the same edge as the inputs that cause them; the block adds no latency to hazard response.
- Load-use costs exactly 1 bubble.
- A taken branch costs 3 squashed slots.
- A memory access completing with ack in the first cycle costs 0 cycles. Ack after N wait cycles costs N freeze cycles.
- The wait counter counts MEM_WAIT cycles. ERROR is entered on the edge after the TIMEOUT-th MEM_WAIT cycle without ack.
- Reset asserted mid-MEM_WAIT or in ERROR: the next edge returns to RUN, clears the counters and clears bus_error.

## Test plan
- Load-use: idex_mem_read = 1, idex_rd = 5, id_rs2 = 5 for one cycle -> pc_write = 0, ifid_write = 0, idex_flush = 1 for that cycle only; stall_count = 1. The same stimulus with idex_rd = 0 -> no stall.
- Taken branch: exmem_branch = 1, exmem_zero = 1 -> pc_src = 1 and ifid/idex/exmem_flush = 1 for 1 cycle; flush_count = 1. With exmem_zero = 0 -> no flush.
- Slow load: exmem_mem_read = 1, dmem_ack on the 4th cycle -> 3 freeze cycles with memwb_flush = 1 and dmem_req high throughout, then normal flow; stall_count = 3.
- Timeout with TIMEOUT = 4: mem_op held, no ack -> ERROR after 4 MEM_WAIT cycles; bus_error = 1 and stays set; dmem_req = 0. Reset clears bus_error and returns to RUN.
- Simultaneous: load_use and taken in the same cycle -> flush only, pc_write = 1, stall_count unchanged. mem_op with ack pending and taken -> freeze first, then flush on the release cycle.
- Saturation with CW = 3: 10 load-use stalls -> stall_count = 7. Reset asserted mid-MEM_WAIT -> all flush outputs = 1 during reset, state RUN afterwards.
